// File: rtl/csa_pkg.sv
// Shared carry-save helpers for the reduction tree: the 3:2 row, the 4:2 compressor,
// and the level-count rule. Rows are built at CSA_MAX_W bits and truncated by the caller.
package csa_pkg;

   localparam int CSA_MAX_W   = 1024;
   localparam int NUM_OPS_DEF = 8;

   typedef logic [CSA_MAX_W-1:0] csa_word_t;

   typedef struct packed {
      csa_word_t s;
      csa_word_t c;
   } csa_row_t;

   function automatic int num_levels(input int n);
      return $clog2(n) - 1;
   endfunction

   localparam int LEVELS = num_levels(NUM_OPS_DEF);

   // Bits above the caller's width never feed lower bits, so truncation afterwards is exact.
   function automatic csa_row_t csa3(input csa_word_t a, input csa_word_t b, input csa_word_t c);
      csa_row_t r;
      r.s = a ^ b ^ c;
      r.c = ((a & b) | (a & c) | (b & c)) << 1;
      return r;
   endfunction

   function automatic csa_row_t comp42(input csa_word_t a, input csa_word_t b,
                                       input csa_word_t c, input csa_word_t d);
      csa_row_t r1;
      r1 = csa3(a, b, c);
      return csa3(r1.s, r1.c, d);
   endfunction

   function automatic csa_word_t row_s(input csa_row_t r);
      return r.s;
   endfunction

   function automatic csa_word_t row_c(input csa_row_t r);
      return r.c;
   endfunction

endpackage

// File: rtl/csa_pipe_stage.sv
// One register slice of the reduction pipe: valid bit, data and tag with a
// skid-free ready chain (ready when empty or when the next slice takes our data).
module csa_pipe_stage #(
   parameter int DW    = 8,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [DW-1:0]    in_data,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             nxt_rdy,
   output logic             rdy,
   output logic             vld,
   output logic [DW-1:0]    data,
   output logic [TAG_W-1:0] tag
);

   logic             vld_d,  vld_q;
   logic [DW-1:0]    data_d, data_q;
   logic [TAG_W-1:0] tag_d,  tag_q;

   assign rdy  = ~vld_q | nxt_rdy;
   assign vld  = vld_q;
   assign data = data_q;
   assign tag  = tag_q;

   // Payload only moves with a real set; bubbles leave the last contents in place.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (rdy) begin
         vld_d = in_vld;
         if (in_vld) begin
            data_d = in_data;
            tag_d  = in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         tag_q  <= tag_d;
      end
   end

endmodule

// File: rtl/csa_reduce_pipe.sv
// Pipelined carry-save reduction of NUM_OPS operands to a sum/carry pair, one register
// slice per 4:2 level, with an optional registered carry-propagate add on the end.
module csa_reduce_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH     = 128,
   parameter int NUM_OPS   = NUM_OPS_DEF,
   parameter int TAG_W     = 8,
   parameter int FINAL_ADD = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] in_ops,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_s,
   output logic [WIDTH-1:0]         out_c,
   output logic [WIDTH-1:0]         out_sum,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int LVLS   = num_levels(NUM_OPS);
   localparam int STAGES = LVLS + ((FINAL_ADD != 0) ? 1 : 0);

   // Index k is the input side of stage k; index STAGES is the output port side.
   logic             vld_pipe [STAGES+1];
   logic             rdy_pipe [STAGES+1];
   logic [TAG_W-1:0] tag_pipe [STAGES+1];

   assign vld_pipe[0]      = in_valid;
   assign tag_pipe[0]      = in_tag;
   assign rdy_pipe[STAGES] = out_ready;
   assign in_ready         = rdy_pipe[0];
   assign out_valid        = vld_pipe[STAGES];
   assign out_tag          = tag_pipe[STAGES];

   for (genvar k = 0; k < LVLS; k++) begin : g_lvl
      localparam int RI = NUM_OPS >> k;
      localparam int RO = RI / 2;

      logic [RI-1:0][WIDTH-1:0] rows_in;
      logic [RO-1:0][WIDTH-1:0] rows_out;
      logic [RO-1:0][WIDTH-1:0] rows_q;

      if (k == 0) begin : g_src
         assign rows_in = in_ops;
      end else begin : g_src
         assign rows_in = g_lvl[k-1].rows_q;
      end

      // Each group of four rows collapses to one sum row and one carry row.
      for (genvar j = 0; j < RO / 2; j++) begin : g_grp
         assign rows_out[2*j]   = WIDTH'(row_s(comp42(CSA_MAX_W'(rows_in[4*j]),
                                                      CSA_MAX_W'(rows_in[4*j+1]),
                                                      CSA_MAX_W'(rows_in[4*j+2]),
                                                      CSA_MAX_W'(rows_in[4*j+3]))));
         assign rows_out[2*j+1] = WIDTH'(row_c(comp42(CSA_MAX_W'(rows_in[4*j]),
                                                      CSA_MAX_W'(rows_in[4*j+1]),
                                                      CSA_MAX_W'(rows_in[4*j+2]),
                                                      CSA_MAX_W'(rows_in[4*j+3]))));
      end

      csa_pipe_stage #(
         .DW    (RO * WIDTH),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .in_vld  (vld_pipe[k]),
         .in_data (rows_out),
         .in_tag  (tag_pipe[k]),
         .nxt_rdy (rdy_pipe[k+1]),
         .rdy     (rdy_pipe[k]),
         .vld     (vld_pipe[k+1]),
         .data    (rows_q),
         .tag     (tag_pipe[k+1])
      );
   end

   if (FINAL_ADD != 0) begin : g_cpa
      logic [2:0][WIDTH-1:0] cpa_in;
      logic [2:0][WIDTH-1:0] cpa_q;
      logic [WIDTH-1:0]      last_s, last_c;

      assign last_s = g_lvl[LVLS-1].rows_q[0];
      assign last_c = g_lvl[LVLS-1].rows_q[1];
      // The redundant pair rides along so out_s/out_c stay aligned with out_sum.
      assign cpa_in = {last_s + last_c, last_c, last_s};

      csa_pipe_stage #(
         .DW    (3 * WIDTH),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .in_vld  (vld_pipe[LVLS]),
         .in_data (cpa_in),
         .in_tag  (tag_pipe[LVLS]),
         .nxt_rdy (rdy_pipe[LVLS+1]),
         .rdy     (rdy_pipe[LVLS]),
         .vld     (vld_pipe[LVLS+1]),
         .data    (cpa_q),
         .tag     (tag_pipe[LVLS+1])
      );

      assign out_s   = cpa_q[0];
      assign out_c   = cpa_q[1];
      assign out_sum = cpa_q[2];
   end else begin : g_nocpa
      assign out_s   = g_lvl[LVLS-1].rows_q[0];
      assign out_c   = g_lvl[LVLS-1].rows_q[1];
      assign out_sum = '0;
   end

endmodule
